// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Channel indices are 2 bits wide, so round-robin arithmetic wraps modulo 4.
package regfile_write_arbiter_pkg;
  localparam int NCH        = 4;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] ch_idx_t;
  typedef logic [1:0] fifo_cnt_t;

  function automatic ch_idx_t rr_next(input ch_idx_t idx);
    return ch_idx_t'(idx + 2'd1);
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Producer-side valid/ready bundle plus the two registered write ports of the register file.
interface regfile_write_arbiter_if #(
  parameter int log2regs = 3,
  parameter int size     = 32
);
  import regfile_write_arbiter_pkg::*;

  logic [NCH-1:0]          in_valid;
  logic [NCH-1:0]          in_ready;
  logic [NCH*log2regs-1:0] in_addr;
  logic [NCH*size-1:0]     in_data;

  logic                    WE0;
  logic [log2regs-1:0]     address_in0;
  logic [size-1:0]         in0;
  logic                    WE1;
  logic [log2regs-1:0]     address_in1;
  logic [size-1:0]         in1;

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, WE0, address_in0, in0, WE1, address_in1, in1
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, WE0, address_in0, in0, WE1, address_in1, in1
  );
endinterface

// File: rtl/regfile_write_arbiter_fifo2.sv
// Two-entry valid/ready FIFO; ready depends on occupancy only, so a full FIFO
// refuses a push even in a cycle where its head is popped.
module regfile_write_fifo2
  import regfile_write_arbiter_pkg::*;
#(
  parameter int W = 35
) (
  input  logic          CGRA_Clock,
  input  logic          CGRA_Reset,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output fifo_cnt_t     count
);
  logic [W-1:0] mem_reg [FIFO_DEPTH];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  fifo_cnt_t    count_reg;
  logic         do_push;
  logic         do_pop;

  assign push_ready = (count_reg != fifo_cnt_t'(FIFO_DEPTH));
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & (count_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge CGRA_Clock) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Four buffered producers round-robin arbitrated onto the two register-file write ports.
// The first non-empty channel always drives port 0, the next one port 1.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int log2regs = 3,
  parameter int size     = 32
) (
  input  logic                     CGRA_Clock,
  input  logic                     CGRA_Reset,
  regfile_write_arbiter_if.slave   wr_bus,
  output logic                     busy
);
  localparam int EW = log2regs + size;

  logic [log2regs-1:0] head_addr [NCH];
  logic [size-1:0]     head_data [NCH];
  fifo_cnt_t           count [NCH];
  logic [NCH-1:0]      nonempty;
  logic [NCH-1:0]      fifo_ready;
  logic [NCH-1:0]      pop;

  ch_idx_t rr_ptr_reg;
  ch_idx_t a_idx, b_idx, scan_idx;
  logic    a_found, b_found;
  logic    grant_a, grant_b;

  logic                we0_reg, we1_reg;
  logic [log2regs-1:0] addr0_reg, addr1_reg;
  logic [size-1:0]     data0_reg, data1_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_fifo
      logic [EW-1:0] head_word;

      regfile_write_fifo2 #(.W(EW)) u_fifo (
        .CGRA_Clock (CGRA_Clock),
        .CGRA_Reset (CGRA_Reset),
        .push_valid (wr_bus.in_valid[gi]),
        .push_ready (fifo_ready[gi]),
        .push_data  ({wr_bus.in_addr[gi*log2regs +: log2regs], wr_bus.in_data[gi*size +: size]}),
        .pop        (pop[gi]),
        .head_data  (head_word),
        .count      (count[gi])
      );

      assign head_addr[gi] = head_word[EW-1 -: log2regs];
      assign head_data[gi] = head_word[size-1:0];
      assign nonempty[gi]  = (count[gi] != '0);
    end
  endgenerate

  assign wr_bus.in_ready = fifo_ready;

  // B is only the immediate successor of A in scan order; a same-address B waits.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = rr_ptr_reg + ch_idx_t'(k);
      if (nonempty[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
    grant_a = a_found;
    grant_b = b_found && (head_addr[b_idx] != head_addr[a_idx]);
    pop     = '0;
    if (grant_a) pop[a_idx] = 1'b1;
    if (grant_b) pop[b_idx] = 1'b1;
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      rr_ptr_reg <= '0;
      we0_reg    <= 1'b0;
      we1_reg    <= 1'b0;
      addr0_reg  <= '0;
      addr1_reg  <= '0;
      data0_reg  <= '0;
      data1_reg  <= '0;
    end else begin
      we0_reg <= grant_a;
      we1_reg <= grant_b;
      if (grant_a) begin
        addr0_reg <= head_addr[a_idx];
        data0_reg <= head_data[a_idx];
      end
      if (grant_b) begin
        addr1_reg <= head_addr[b_idx];
        data1_reg <= head_data[b_idx];
      end
      if (grant_b)      rr_ptr_reg <= rr_next(b_idx);
      else if (grant_a) rr_ptr_reg <= rr_next(a_idx);
    end
  end

  assign wr_bus.WE0         = we0_reg;
  assign wr_bus.address_in0 = addr0_reg;
  assign wr_bus.in0         = data0_reg;
  assign wr_bus.WE1         = we1_reg;
  assign wr_bus.address_in1 = addr1_reg;
  assign wr_bus.in1         = data1_reg;

  assign busy = (|nonempty) | we0_reg | we1_reg;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single/dual issue, address conflict,
// backpressure with fairness, full-FIFO refusal and asynchronous reset.
module tb_regfile_write_arbiter;
  localparam int L2R = 3;
  localparam int SZ  = 32;

  logic CGRA_Clock = 1'b0;
  logic CGRA_Reset = 1'b1;
  logic busy;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_write_arbiter_if #(.log2regs(L2R), .size(SZ)) bus ();

  regfile_write_arbiter #(.log2regs(L2R), .size(SZ)) dut (
    .CGRA_Clock (CGRA_Clock),
    .CGRA_Reset (CGRA_Reset),
    .wr_bus     (bus),
    .busy       (busy)
  );

  always #5 CGRA_Clock = ~CGRA_Clock;

  task automatic tick();
    @(posedge CGRA_Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic [L2R-1:0] a, input logic [SZ-1:0] d);
    bus.in_valid[ch]         = v;
    bus.in_addr[ch*L2R +: L2R] = a;
    bus.in_data[ch*SZ +: SZ]   = d;
  endtask

  task automatic do_reset();
    CGRA_Reset = 1'b1;
    tick();
    tick();
    CGRA_Reset = 1'b0;
  endtask

  // Per-cycle line of the write ports; returns which channels (identified by address) were written.
  task automatic observe(output logic [3:0] mask, inout int exp0);
    mask = '0;
    $display("t=%0t WE0=%0b a0=%0d d0=%0h WE1=%0b a1=%0d d1=%0h rdy=%b",
             $time, bus.WE0, bus.address_in0, bus.in0, bus.WE1, bus.address_in1, bus.in1, bus.in_ready);
    if (bus.WE0) begin
      mask[bus.address_in0[1:0]] = 1'b1;
      if (bus.address_in0 == 3'd0) begin
        check("ch0_order_p0", 64'(bus.in0), 64'(exp0));
        exp0++;
      end
    end
    if (bus.WE1) begin
      mask[bus.address_in1[1:0]] = 1'b1;
      if (bus.address_in1 == 3'd0) begin
        check("ch0_order_p1", 64'(bus.in1), 64'(exp0));
        exp0++;
      end
    end
  endtask

  initial begin
    logic [3:0] cur_mask, prev_mask;
    logic       rdy;
    int         sent, exp0, viol, it;
    logic       saw_low;

    bus.in_valid = '0;
    bus.in_addr  = '0;
    bus.in_data  = '0;

    // Reset state
    tick();
    tick();
    check("rst_we0", 64'(bus.WE0), 64'd0);
    check("rst_we1", 64'(bus.WE1), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'hF);
    check("rst_addr0", 64'(bus.address_in0), 64'd0);
    check("rst_in1", 64'(bus.in1), 64'd0);
    CGRA_Reset = 1'b0;

    // Single write on ch2, two-edge latency
    drive(2, 1'b1, 3'd5, 32'hDEADBEEF);
    tick();
    drive(2, 1'b0, 3'd0, 32'h0);
    check("single_no_bypass", 64'(bus.WE0), 64'd0);
    check("single_busy_buf", 64'(busy), 64'd1);
    tick();
    $display("single: WE0=%0b a0=%0d d0=%0h WE1=%0b", bus.WE0, bus.address_in0, bus.in0, bus.WE1);
    check("single_we0", 64'(bus.WE0), 64'd1);
    check("single_addr0", 64'(bus.address_in0), 64'd5);
    check("single_in0", 64'(bus.in0), 64'hDEADBEEF);
    check("single_we1", 64'(bus.WE1), 64'd0);
    tick();
    check("single_we0_drop", 64'(bus.WE0), 64'd0);
    check("single_busy_fall", 64'(busy), 64'd0);
    check("single_addr0_hold", 64'(bus.address_in0), 64'd5);

    // rr_ptr is now 3: ch3 is scanned before ch0
    drive(0, 1'b1, 3'd1, 32'h11);
    drive(3, 1'b1, 3'd2, 32'h22);
    tick();
    drive(0, 1'b0, 3'd0, 32'h0);
    drive(3, 1'b0, 3'd0, 32'h0);
    tick();
    $display("rr3 dual: a0=%0d d0=%0h a1=%0d d1=%0h", bus.address_in0, bus.in0, bus.address_in1, bus.in1);
    check("rr3_we0", 64'(bus.WE0), 64'd1);
    check("rr3_addr0", 64'(bus.address_in0), 64'd2);
    check("rr3_in0", 64'(bus.in0), 64'h22);
    check("rr3_we1", 64'(bus.WE1), 64'd1);
    check("rr3_addr1", 64'(bus.address_in1), 64'd1);
    check("rr3_in1", 64'(bus.in1), 64'h11);

    // Dual issue from rr_ptr=0
    do_reset();
    drive(0, 1'b1, 3'd1, 32'h11);
    drive(3, 1'b1, 3'd2, 32'h22);
    tick();
    drive(0, 1'b0, 3'd0, 32'h0);
    drive(3, 1'b0, 3'd0, 32'h0);
    tick();
    $display("rr0 dual: a0=%0d d0=%0h a1=%0d d1=%0h", bus.address_in0, bus.in0, bus.address_in1, bus.in1);
    check("dual_we0", 64'(bus.WE0), 64'd1);
    check("dual_addr0", 64'(bus.address_in0), 64'd1);
    check("dual_in0", 64'(bus.in0), 64'h11);
    check("dual_we1", 64'(bus.WE1), 64'd1);
    check("dual_addr1", 64'(bus.address_in1), 64'd2);
    check("dual_in1", 64'(bus.in1), 64'h22);

    // Address conflict: same address never issued in one cycle
    do_reset();
    drive(1, 1'b1, 3'd4, 32'hA);
    drive(2, 1'b1, 3'd4, 32'hB);
    tick();
    drive(1, 1'b0, 3'd0, 32'h0);
    drive(2, 1'b0, 3'd0, 32'h0);
    tick();
    $display("conflict c1: WE0=%0b a0=%0d d0=%0h WE1=%0b", bus.WE0, bus.address_in0, bus.in0, bus.WE1);
    check("conf1_we0", 64'(bus.WE0), 64'd1);
    check("conf1_addr0", 64'(bus.address_in0), 64'd4);
    check("conf1_in0", 64'(bus.in0), 64'hA);
    check("conf1_we1", 64'(bus.WE1), 64'd0);
    tick();
    $display("conflict c2: WE0=%0b a0=%0d d0=%0h WE1=%0b", bus.WE0, bus.address_in0, bus.in0, bus.WE1);
    check("conf2_we0", 64'(bus.WE0), 64'd1);
    check("conf2_in0", 64'(bus.in0), 64'hB);
    check("conf2_we1", 64'(bus.WE1), 64'd0);
    check("conf2_addr1_untouched", 64'(bus.address_in1), 64'd0);
    tick();
    check("conf3_we0", 64'(bus.WE0), 64'd0);

    // Backpressure and fairness: ch0 streams 0..9 while ch1..3 saturate
    do_reset();
    sent = 0; exp0 = 0; viol = 0; it = 0; saw_low = 1'b0; prev_mask = '0;
    while (sent < 10 && it < 100) begin
      drive(0, 1'b1, 3'd0, 32'(sent));
      for (int c = 1; c < 4; c++) drive(c, 1'b1, 3'(c), 32'((it << 4) | c));
      rdy = bus.in_ready[0];
      if (!rdy) saw_low = 1'b1;
      tick();
      if (rdy) sent++;
      observe(cur_mask, exp0);
      if (it >= 2) begin
        for (int c = 0; c < 4; c++)
          if (!(cur_mask[c] | prev_mask[c])) viol++;
      end
      prev_mask = cur_mask;
      it++;
    end
    check("bp_all_sent", 64'(sent), 64'd10);
    bus.in_valid = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      observe(cur_mask, exp0);
    end
    check("bp_ready_dropped", 64'(saw_low), 64'd1);
    check("bp_ch0_count", 64'(exp0), 64'd10);
    check("bp_fairness_viol", 64'(viol), 64'd0);
    check("bp_idle", 64'(busy), 64'd0);

    // Full FIFO refuses a push even while popping; move rr_ptr to 2 first
    do_reset();
    drive(1, 1'b1, 3'd7, 32'h77);
    tick();
    drive(1, 1'b0, 3'd0, 32'h0);
    tick();
    tick();
    drive(0, 1'b1, 3'd0, 32'h100);
    drive(2, 1'b1, 3'd2, 32'h200);
    drive(3, 1'b1, 3'd3, 32'h300);
    tick();
    drive(2, 1'b0, 3'd0, 32'h0);
    drive(3, 1'b0, 3'd0, 32'h0);
    drive(0, 1'b1, 3'd0, 32'h101);
    check("full_ready_c1", 64'(bus.in_ready[0]), 64'd1);
    tick();
    $display("full e2: a0=%0d a1=%0d rdy=%b", bus.address_in0, bus.address_in1, bus.in_ready);
    check("full_e2_addr0", 64'(bus.address_in0), 64'd2);
    check("full_e2_addr1", 64'(bus.address_in1), 64'd3);
    check("full_ready_low", 64'(bus.in_ready[0]), 64'd0);
    drive(0, 1'b1, 3'd0, 32'h102);
    tick();
    $display("full e3: WE0=%0b d0=%0h WE1=%0b rdy=%b", bus.WE0, bus.in0, bus.WE1, bus.in_ready);
    check("full_e3_in0", 64'(bus.in0), 64'h100);
    check("full_e3_we1", 64'(bus.WE1), 64'd0);
    check("full_ready_back", 64'(bus.in_ready[0]), 64'd1);
    tick();
    drive(0, 1'b0, 3'd0, 32'h0);
    check("full_e4_in0", 64'(bus.in0), 64'h101);
    tick();
    check("full_e5_we0", 64'(bus.WE0), 64'd1);
    check("full_e5_in0", 64'(bus.in0), 64'h102);
    tick();
    check("full_e6_we0", 64'(bus.WE0), 64'd0);
    check("full_e6_busy", 64'(busy), 64'd0);

    // Asynchronous reset between edges with all FIFOs loaded
    do_reset();
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 3'(c), 32'(c + 16));
    tick();
    tick();
    tick();
    tick();
    check("arst_pre_we0", 64'(bus.WE0), 64'd1);
    #2;
    CGRA_Reset = 1'b1;
    #1;
    $display("arst: WE0=%0b WE1=%0b busy=%0b rdy=%b", bus.WE0, bus.WE1, busy, bus.in_ready);
    check("arst_we", 64'({bus.WE0, bus.WE1}), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(bus.in_ready), 64'hF);
    bus.in_valid = '0;
    tick();
    tick();
    CGRA_Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_no_we_after", 64'({bus.WE0, bus.WE1, busy}), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
